// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to RESET_VAL.
`timescale 1ns/1ps
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output.
// Handshake: a byte transfers on any rising edge where rx_valid && rx_ready;
// rx_data is held stable while rx_valid is high and not yet accepted.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t  state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            rx_s;

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // A start bit that is high again at its midpoint was a glitch.
          if (cnt == MID) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              // A same-cycle handshake frees the slot, so the new byte can load.
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CPB    = 16;
  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CPB * CLK_NS;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic [7:0] exp_q[$];
  int n_tests;
  int n_fail;
  int valid_cycles;
  int fe_cnt;
  int ov_cnt;
  int acc_cnt;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #(CLK_NS / 2.0) clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: start bit, 8 data bits LSB first, stop bit; line is left at stop_val
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard: sampled on the falling edge, away from the active edge
  task automatic monitor();
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (rx_valid) begin
          valid_cycles++;
          if (rx_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_byte", {24'h0, rx_data}, 32'hdead);
            end else begin
              exp = exp_q.pop_front();
              check("rx_data", {24'h0, rx_data}, {24'h0, exp});
              acc_cnt++;
            end
          end
        end
      end
    end
  endtask

  initial begin
    int v0, f0, o0, a0;
    logic [7:0] sweep_bytes[3];
    real sweep_scale[2];

    n_tests = 0; n_fail = 0;
    valid_cycles = 0; fe_cnt = 0; ov_cnt = 0; acc_cnt = 0;
    rx = 1'b1; rx_ready = 1'b1; rst_n = 1'b0;
    fork monitor(); join_none

    // reset state
    wait_cycles(3);
    check("rst_rx_data",   {24'h0, rx_data}, 32'h00);
    check("rst_rx_valid",  {31'h0, rx_valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // single byte 0xA5
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    check("a5_valid_cycles", valid_cycles - v0, 1);
    check("a5_frame_err", fe_cnt - f0, 0);
    check("a5_overrun", ov_cnt - o0, 0);
    check("a5_drained", exp_q.size(), 0);

    // back-to-back with consumer stalled: second byte overruns
    @(posedge clk); #1 rx_ready = 1'b0;
    o0 = ov_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    send_frame(8'hC3, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    @(negedge clk);
    check("ovr_valid_held", {31'h0, rx_valid}, 32'h1);
    check("ovr_data_held", {24'h0, rx_data}, 32'h3C);
    check("ovr_pulses", ov_cnt - o0, 1);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_valid_drop", {31'h0, rx_valid}, 32'h0);
    check("ovr_drained", exp_q.size(), 0);

    // framing error: 0xFF with stop low, then break held low
    v0 = valid_cycles; f0 = fe_cnt;
    send_frame(8'hFF, 1'b0, BIT_NS);
    #(3 * BIT_NS);
    @(negedge clk);
    check("fe_pulses", fe_cnt - f0, 1);
    check("fe_no_valid", valid_cycles - v0, 0);
    check("fe_busy_in_break", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    wait_cycles(6);
    check("fe_busy_released", {31'h0, busy}, 32'h0);

    // 4-cycle glitch on idle line
    v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_start", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    check("glitch_busy_idle", {31'h0, busy}, 32'h0);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_fe", fe_cnt - f0, 0);
    check("glitch_no_ovr", ov_cnt - o0, 0);

    // reset during data bit 4 of 0x55, then receive 0x81
    a0 = acc_cnt;
    fork
      send_frame(8'h55, 1'b1, BIT_NS);
      begin
        #(5.5 * BIT_NS);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_valid", {31'h0, rx_valid}, 32'h0);
      end
    join
    wait_cycles(3);
    rst_n = 1'b1;
    #(2 * BIT_NS);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    check("midrst_accepted", acc_cnt - a0, 1);

    // baud error sweep at -3% / +3%
    sweep_bytes[0] = 8'h00; sweep_bytes[1] = 8'hFF; sweep_bytes[2] = 8'h5A;
    sweep_scale[0] = 0.97;  sweep_scale[1] = 1.03;
    a0 = acc_cnt; f0 = fe_cnt;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 3; b++) begin
        exp_q.push_back(sweep_bytes[b]);
        send_frame(sweep_bytes[b], 1'b1, BIT_NS * sweep_scale[s]);
        #(BIT_NS);
      end
    end
    #(2 * BIT_NS);
    check("sweep_accepted", acc_cnt - a0, 6);
    check("sweep_no_fe", fe_cnt - f0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per bit period (100 MHz / 115200 baud); legal range 8..65535.
- REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
- REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
- REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
- REQ-005 SHALL have port rx_data  output  8  received byte, held stable while rx_valid=1.
- REQ-006 SHALL have port rx_valid  output  1  byte available.
- REQ-007 SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready.
- REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
- REQ-009 SHALL have port overrun  output  1  one-cycle pulse: new byte completed while rx_valid=1 and not accepted.
- REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
- REQ-011 rx SHALL pass through a 2-flop synchronizer; rx_s is the output; all further logic uses rx_s only.
- REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
- REQ-013 IDLE: rx_s=0 SHALL move to START and clear the bit-period counter.
- REQ-014 START: at count CLKS_PER_BIT/2-1 (mid start bit), rx_s=1 SHALL return to IDLE (glitch reject, no flags); rx_s=0 SHALL move to DATA and clear the counter.
- REQ-015 DATA: each time the counter reaches CLKS_PER_BIT-1 SHALL sample rx_s into shift-register bit[index], index 0..7; after index 7 SHALL move to STOP.
- REQ-016 STOP: at count CLKS_PER_BIT-1 with rx_s=1 SHALL complete the byte and go to IDLE; with rx_s=0 SHALL pulse frame_err, discard the byte, and go to WAIT_IDLE.
- REQ-017 WAIT_IDLE SHALL remain until rx_s=1, then go to IDLE (no restart on break condition).
- REQ-018 Bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1.
- REQ-019 On completion, rx_data and rx_valid=1 SHALL update on the clock edge after the mid-stop sample (latency: falling edge of start on rx to rx_valid = 2 sync cycles + 9.5 bit periods + 1 cycle, +/-1 cycle).
- REQ-020 rx_valid SHALL stay high and rx_data stable until rx_valid&rx_ready; the handshake cycle SHALL clear rx_valid on the next edge.
- REQ-021 Completion while rx_valid=1 and rx_ready=0 SHALL pulse overrun, keep the old rx_data, and discard the new byte.
- REQ-022 Completion in the same cycle as a handshake SHALL load the new byte with rx_valid staying 1 and no overrun.
- REQ-023 Reception SHALL continue in all states regardless of rx_valid/rx_ready.

Reset
- REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, counters=0, shift register=0, synchronizer flops=1, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- REQ-025 Reset mid-frame SHALL abandon the frame; after release the block SHALL wait for the next high-to-low edge on rx_s.

Structure
- REQ-026 uart_pkg SHALL hold the FSM state enum uart_rx_state_t and the constant DEFAULT_CLKS_PER_BIT=868.
- REQ-027 The synchronizer SHALL be a sub-module uart_sync_2ff with its flops marked ASYNC_REG.
- REQ-028 Implementation SHALL be synthesizable, with no latches and no gated clocks.

Verification (bench CLKS_PER_BIT=16, rx_ready=1 unless stated)
- REQ-029 Send 8'hA5 with a valid stop bit -> rx_data=8'hA5, rx_valid high one cycle, frame_err=0, overrun=0.
- REQ-030 Send 8'h3C then 8'hC3 back-to-back with rx_ready=0 -> rx_data stays 8'h3C, overrun pulses once; raising rx_ready -> rx_valid drops the next cycle.
- REQ-031 Send 8'hFF with the stop bit driven low -> frame_err pulses once, rx_valid=0, busy=1 until rx returns high.
- REQ-032 Drive a 4-cycle low glitch on an idle line -> returns to IDLE, no rx_valid, no flags.
- REQ-033 Assert rst_n=0 during data bit 4 of 8'h55, release, then send 8'h81 -> only 8'h81 received.
- REQ-034 Baud-error sweep at +/-3% bit period, bytes 8'h00, 8'hFF, 8'h5A -> all received correctly.
